// File: rtl/prg_injector.sv
// prg_injector: writes a PRG image from the loader stream into C64 RAM, then patches the BASIC end pointers
// Ports: clk/reset_n (async active-low); load_prg, ioctl_* loader stream in, ioctl_wait back-pressure out;
//        ram_addr/ram_data/ram_we/ram_ack RAM write handshake; busy, prg_done, prg_err status;
//        load_start/load_end image address range.
module prg_injector (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_prg,
  input  logic        ioctl_download,
  input  logic [22:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  input  logic        ram_ack,
  output logic        busy,
  output logic        prg_done,
  output logic        prg_err,
  output logic [15:0] load_start,
  output logic [15:0] load_end
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, RAM_WAIT, PTR, PTR_WAIT, DONE} state_t;
  // zero-page pointer low bytes, index 0 in the least significant byte
  localparam logic [63:0] PTR_TAB = {8'hAF, 8'hAE, 8'h32, 8'h31, 8'h30, 8'h2F, 8'h2E, 8'h2D};
  state_t      state_q, state_d;
  logic        dl_q;
  logic        end_q, end_d;
  logic [2:0]  ptr_idx_q, ptr_idx_d;
  logic        wait_q, wait_d, we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0] addr_q, addr_d, ls_q, ls_d, le_q, le_d;
  logic [7:0]  data_q, data_d;
  logic        rise, fall, wr;
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  assign wr   = ioctl_wr & load_prg;
  assign ioctl_wait = wait_q;
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;
  assign ram_we     = we_q;
  assign busy       = busy_q;
  assign prg_done   = done_q;
  assign prg_err    = err_q;
  assign load_start = ls_q;
  assign load_end   = le_q;
  always_comb begin
    state_d   = state_q;
    end_d     = end_q;
    ptr_idx_d = ptr_idx_q;
    wait_d    = wait_q;
    we_d      = we_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ls_d      = ls_q;
    le_d      = le_q;
    case (state_q)
      IDLE: if (rise && load_prg) begin
        err_d     = 1'b0;
        ls_d      = '0;
        le_d      = '0;
        ptr_idx_d = '0;
        end_d     = 1'b0;
        state_d   = HDR;
      end
      HDR: if (fall) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else if (wr && ioctl_addr == 23'd0) begin
        ls_d[7:0] = ioctl_data;
        busy_d    = 1'b1;
      end else if (wr && ioctl_addr == 23'd1) begin
        ls_d[15:8] = ioctl_data;
        le_d       = {ioctl_data, ls_q[7:0]};
        busy_d     = 1'b1;
        state_d    = DATA;
      end
      DATA: if (fall) begin
        wait_d  = 1'b1;
        state_d = PTR;
      end else if (wr && ioctl_addr >= 23'd2) begin
        // offsets past a full 64K image would wrap onto already written RAM
        if (ioctl_addr >= 23'd65538) err_d = 1'b1;
        else begin
          addr_d  = ls_q + ioctl_addr[15:0] - 16'd2;
          data_d  = ioctl_data;
          we_d    = 1'b1;
          wait_d  = 1'b1;
          state_d = RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        if (fall) end_d = 1'b1;
        if (ram_ack) begin
          we_d    = 1'b0;
          le_d    = addr_q + 16'd1;
          wait_d  = end_q || fall;
          state_d = (end_q || fall) ? PTR : DATA;
        end
      end
      PTR: begin
        addr_d  = {8'h00, PTR_TAB[{ptr_idx_q, 3'b000} +: 8]};
        data_d  = ptr_idx_q[0] ? le_q[15:8] : le_q[7:0];
        we_d    = 1'b1;
        state_d = PTR_WAIT;
      end
      PTR_WAIT: if (ram_ack) begin
        we_d = 1'b0;
        if (ptr_idx_q == 3'd7) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          wait_d  = 1'b0;
          state_d = DONE;
        end else begin
          ptr_idx_d = ptr_idx_q + 3'd1;
          state_d   = PTR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a strobe the loader was told to hold off, or one arriving after end of stream, is an overrun
    if (ioctl_wr && (wait_q || state_q == PTR || state_q == PTR_WAIT)) err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      dl_q      <= 1'b0;
      end_q     <= 1'b0;
      ptr_idx_q <= '0;
      wait_q    <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      ls_q      <= '0;
      le_q      <= '0;
    end else begin
      state_q   <= state_d;
      dl_q      <= ioctl_download;
      end_q     <= end_d;
      ptr_idx_q <= ptr_idx_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ls_q      <= ls_d;
      le_q      <= le_d;
    end
endmodule

// File: tb/tb_prg_injector.sv
// tb_prg_injector: randomized and directed PRG images checked against a behavioural image-to-RAM model
module tb_prg_injector;
  logic        clk = 1'b0, reset_n = 1'b0, load_prg = 1'b0, ioctl_download = 1'b0, ioctl_wr = 1'b0, ram_ack = 1'b0;
  logic [22:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wait, ram_we, busy, prg_done, prg_err;
  logic [15:0] ram_addr, load_start, load_end;
  logic [7:0]  ram_data;
  int n_cmp = 0, n_bad = 0, ack_dly = 0, done_cnt = 0, stable_bad = 0, wc;
  logic [23:0] rec_q[$];
  logic [7:0]  img[$];
  logic [15:0] ptrs[8] = '{16'h002D, 16'h002E, 16'h002F, 16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};

  prg_injector dut (
    .clk(clk), .reset_n(reset_n), .load_prg(load_prg), .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_ack(ram_ack),
    .busy(busy), .prg_done(prg_done), .prg_err(prg_err), .load_start(load_start), .load_end(load_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM arbiter: records each write request, acks after ack_dly extra cycles, watches hold stability
  initial begin
    logic [23:0] w;
    forever begin
      @(posedge clk); #1;
      if (ram_we && reset_n) begin
        w = {ram_addr, ram_data};
        rec_q.push_back(w);
        for (int i = 0; i < ack_dly && reset_n; i++) begin
          @(posedge clk); #1;
          if (reset_n && (!ram_we || {ram_addr, ram_data} !== w)) stable_bad++;
        end
        if (reset_n) begin
          ram_ack = 1'b1;
          @(posedge clk); #1;
          ram_ack = 1'b0;
          if (reset_n && ram_we) stable_bad++;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (prg_done) done_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input int a, input logic [7:0] d, output int w);
    int g = 0;
    while (ioctl_wait && g < 200) begin @(posedge clk); #1; g++; end
    ioctl_addr = 23'(a); ioctl_data = d; ioctl_wr = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    w = 0;
    while (ioctl_wait && w < 200) begin @(posedge clk); #1; w++; end
  endtask

  // image -> expected RAM writes, computed straight from the PRG format
  task automatic run_image(input int dly, input bit prg, input int inj);
    logic [23:0] exp_q[$];
    logic [15:0] ls, le;
    bit err;
    int n, t, d0;
    n = img.size();
    ack_dly = dly; load_prg = prg; rec_q.delete(); d0 = done_cnt; stable_bad = 0;
    err = (n < 2) || (inj >= 2);
    ls = (n >= 2) ? {img[1], img[0]} : (n == 1) ? {8'h00, img[0]} : 16'h0000;
    le = (n >= 2) ? 16'(ls + n - 2) : 16'h0000;
    for (int i = 2; i < n; i++) exp_q.push_back({16'(ls + i - 2), img[i]});
    if (n >= 2) for (int p = 0; p < 8; p++) exp_q.push_back({ptrs[p], p[0] ? le[15:8] : le[7:0]});
    if (!prg) exp_q.delete();
    @(posedge clk); #1; ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == inj) begin
        ioctl_addr = 23'(i); ioctl_data = img[i]; ioctl_wr = 1'b1;
        @(posedge clk); #1;
        ioctl_addr = 23'(i + 1); ioctl_data = 8'h5A;
        @(posedge clk); #1;
        ioctl_wr = 1'b0;
        wc = 0;
        while (ioctl_wait && wc < 200) begin @(posedge clk); #1; wc++; end
      end else send(i, img[i], wc);
      chk($sformatf("wait_cycles[%0d]", i), wc, (i < 2 || !prg) ? 0 : (i == inj) ? dly : dly + 1);
    end
    ioctl_download = 1'b0;
    if (prg && n >= 2) begin
      @(posedge clk); #1;
      chk("ptr_we_e1", ram_we, 0);
      chk("busy_mid", busy, 1);
      chk("wait_after_end", ioctl_wait, 1);
      @(posedge clk); #1;
      chk("ptr_we_e2", ram_we, 1);
    end
    t = 0;
    while ((prg ? done_cnt == d0 : t < 20) && t < 400) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - d0, prg ? 1 : 0);
    chk("busy_end", busy, 0);
    chk("wait_end", ioctl_wait, 0);
    if (prg) begin
      chk("prg_err", prg_err, err);
      chk("load_start", load_start, ls);
      chk("load_end", load_end, le);
    end
    chk("n_writes", rec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++)
      chk($sformatf("write[%0d]", i), rec_q[i], exp_q[i]);
    chk("hold_stable", stable_bad, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {ioctl_wait, ram_we, busy, prg_done, prg_err}, 0);
    chk("reset_ram", {ram_addr, ram_data}, 0);
    chk("reset_range", {load_start, load_end}, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    img = '{8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC};
    run_image(0, 1'b1, -1);
    run_image(5, 1'b1, -1);
    img = '{8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33};
    run_image(1, 1'b1, -1);
    img = '{8'h7F};
    run_image(0, 1'b1, -1);
    img = '{8'h00, 8'hC0, 8'h01, 8'h02, 8'h03, 8'h04};
    run_image(3, 1'b1, 3);
    img = '{8'h01, 8'h08, 8'hAA};
    run_image(2, 1'b0, -1);
    // reset while a data write is outstanding
    ack_dly = 30; load_prg = 1'b1; rec_q.delete();
    @(posedge clk); #1; ioctl_download = 1'b1;
    @(posedge clk); #1;
    send(0, 8'h00, wc);
    send(1, 8'h20, wc);
    ioctl_addr = 23'd2; ioctl_data = 8'h99; ioctl_wr = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_we", ram_we, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ctl", {ioctl_wait, ram_we, busy, prg_done, prg_err}, 0);
    chk("rst_ram", {ram_addr, ram_data}, 0);
    chk("rst_range", {load_start, load_end}, 0);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1; rec_q.delete();
    img = '{8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC};
    run_image(1, 1'b1, -1);
    for (int k = 0; k < 14; k++) begin
      int len;
      len = $urandom_range(0, 24);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      if (len >= 2 && k % 3 == 0) img[1] = 8'hFF;
      run_image($urandom_range(0, 3), 1'b1, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
